// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - segment bit map, digit patterns and sampling geometry shared with the renderer
package seven_segment_pkg;

    // Mask layout is {a, b, c, d, e, f, g} on bits 6..0
    localparam logic [2:0] SEG_G = 3'd0;
    localparam logic [2:0] SEG_F = 3'd1;
    localparam logic [2:0] SEG_E = 3'd2;
    localparam logic [2:0] SEG_D = 3'd3;
    localparam logic [2:0] SEG_C = 3'd4;
    localparam logic [2:0] SEG_B = 3'd5;
    localparam logic [2:0] SEG_A = 3'd6;

    localparam logic [6:0] PAT_0 = 7'b1111110;
    localparam logic [6:0] PAT_1 = 7'b0110000;
    localparam logic [6:0] PAT_2 = 7'b1101101;
    localparam logic [6:0] PAT_3 = 7'b1111001;
    localparam logic [6:0] PAT_4 = 7'b0110011;
    localparam logic [6:0] PAT_5 = 7'b1011011;
    localparam logic [6:0] PAT_6 = 7'b1011111;
    localparam logic [6:0] PAT_7 = 7'b1110000;
    localparam logic [6:0] PAT_8 = 7'b1111111;
    localparam logic [6:0] PAT_9 = 7'b1111011;

    localparam logic [2:0] XOFS_LEFT  = 3'd3;
    localparam logic [2:0] XOFS_MID   = 3'd5;
    localparam logic [2:0] XOFS_RIGHT = 3'd7;

    localparam logic [4:0] ROW_END_LINE = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        EMIT
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] seg;
    } sample_pt_t;

    function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = PAT_0;
            4'd1:    pat = PAT_1;
            4'd2:    pat = PAT_2;
            4'd3:    pat = PAT_3;
            4'd4:    pat = PAT_4;
            4'd5:    pat = PAT_5;
            4'd6:    pat = PAT_6;
            4'd7:    pat = PAT_7;
            4'd8:    pat = PAT_8;
            4'd9:    pat = PAT_9;
            default: pat = 7'b0000000;
        endcase
        return pat;
    endfunction

    // One pixel per segment, taken away from the corners so neighbouring segments never alias
    function automatic sample_pt_t sample_point(input logic [2:0] yofs, input logic [2:0] xofs);
        sample_pt_t sp;
        sp.hit = 1'b1;
        sp.seg = 3'd0;
        case ({yofs, xofs})
            {3'd0, XOFS_MID}:   sp.seg = SEG_A;
            {3'd1, XOFS_LEFT}:  sp.seg = SEG_F;
            {3'd1, XOFS_RIGHT}: sp.seg = SEG_B;
            {3'd2, XOFS_MID}:   sp.seg = SEG_G;
            {3'd3, XOFS_LEFT}:  sp.seg = SEG_E;
            {3'd3, XOFS_RIGHT}: sp.seg = SEG_C;
            {3'd4, XOFS_MID}:   sp.seg = SEG_D;
            default:            sp.hit = 1'b0;
        endcase
        return sp;
    endfunction

endpackage

// File: rtl/seven_segment_encoder.sv
// rtl/seven_segment_encoder.sv - segment mask to digit, flagging masks that are not a decimal digit
module seven_segment_encoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] i_segments,
    output logic [3:0] o_digit,
    output logic       o_error
);

    always_comb begin
        o_digit = 4'hF;
        o_error = 1'b0;
        case (i_segments)
            PAT_0:   o_digit = 4'd0;
            PAT_1:   o_digit = 4'd1;
            PAT_2:   o_digit = 4'd2;
            PAT_3:   o_digit = 4'd3;
            PAT_4:   o_digit = 4'd4;
            PAT_5:   o_digit = 4'd5;
            PAT_6:   o_digit = 4'd6;
            PAT_7:   o_digit = 4'd7;
            PAT_8:   o_digit = 4'd8;
            PAT_9:   o_digit = 4'd9;
            default: o_error = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - captures one text row of 7-segment digits from the pixel stream and streams them out
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter logic [3:0] ROW = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       pixel,
    output logic [3:0] out_digit,
    output logic [3:0] out_index,
    output logic       out_error,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       overrun
);

    state_t     r_state;
    logic [3:0] r_k;
    logic [6:0] r_seg [16];

    logic       w_in_row;
    logic       w_row_start;
    logic       w_row_end;
    logic [3:0] w_cell;
    sample_pt_t w_sample;
    logic       w_strobe;
    logic       w_accept;
    logic [3:0] w_next_k;
    logic [3:0] w_dec_digit;
    logic       w_dec_error;

    assign w_in_row    = (vpos[8:5] == ROW);
    assign w_row_start = w_in_row && (vpos[4:0] == 5'd0) && (hpos == 9'd0);
    assign w_row_end   = w_in_row && (vpos[4:0] == ROW_END_LINE) && (hpos == 9'd0);
    assign w_cell      = hpos[7:4];
    assign w_sample    = sample_point(vpos[4:2], hpos[3:1]);

    // Odd hpos on the third scanline of each 4-line band lands mid-pixel of the renderer's 2x4 blocks
    assign w_strobe = (r_state == CAPTURE) && display_on && w_in_row &&
                      (vpos[1:0] == 2'd2) && hpos[0] && !hpos[8] && w_sample.hit;

    assign w_accept = out_valid && out_ready;

    // The decoder looks one beat ahead so every beat output can be loaded straight into a register
    assign w_next_k = (r_state == EMIT) ? (r_k + 4'd1) : 4'd0;

    seven_segment_encoder u_encoder (
        .i_segments (r_seg[w_next_k]),
        .o_digit    (w_dec_digit),
        .o_error    (w_dec_error)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_k        <= 4'd0;
            out_digit  <= 4'd0;
            out_index  <= 4'd0;
            out_error  <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_seg[i] <= 7'd0;
            end
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_row_start) begin
                        for (int i = 0; i < 16; i++) begin
                            r_seg[i] <= 7'd0;
                        end
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (w_strobe) begin
                        r_seg[w_cell][w_sample.seg] <= pixel;
                    end
                    if (w_row_end) begin
                        r_state   <= EMIT;
                        r_k       <= 4'd0;
                        out_valid <= 1'b1;
                        out_index <= 4'd0;
                        out_digit <= w_dec_digit;
                        out_error <= w_dec_error;
                    end
                end
                EMIT: begin
                    // A consumer this slow loses the next frame rather than having its store overwritten
                    if (w_row_start) begin
                        overrun <= 1'b1;
                    end
                    if (w_accept) begin
                        if (r_k == 4'd15) begin
                            r_state    <= IDLE;
                            r_k        <= 4'd0;
                            out_valid  <= 1'b0;
                            out_digit  <= 4'd0;
                            out_index  <= 4'd0;
                            out_error  <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            r_k       <= w_next_k;
                            out_index <= w_next_k;
                            out_digit <= w_dec_digit;
                            out_error <= w_dec_error;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Recovers the digits drawn by the 7-segment CRT renderer by sampling its pixel stream. It sits on the video side next to the renderer and taps `hpos`, `vpos`, `display_on` and the green pixel bit. Once per frame it captures one text row of 16 digit cells and stores a 7-bit segment mask per cell. It then streams the 16 recovered digits out over a valid/ready interface, for self-check and loopback testing of the display path.

## Interface
- `ROW`, default 0: text row to capture, compared against `vpos[8:5]` (0..15).
- `clk`  in  1: pixel clock, the same clock that advances `hpos`.
- `reset`  in  1: asynchronous, active-low.
- `display_on`  in  1: visible-area flag from the sync generator.
- `hpos`  in  9: horizontal position, aligned with `pixel` in the same cycle.
- `vpos`  in  9: vertical position.
- `pixel`  in  1: green bit of the rendered image.
- `out_digit`  out  4: decoded digit, 0..9, or 4'hF when the pattern is unknown.
- `out_index`  out  4: cell index, 0..15, left to right.
- `out_error`  out  1: high with a beat whose segment pattern matched no digit.
- `out_valid`  out  1: beat valid.
- `out_ready`  in  1: consumer accepts the beat.
- `frame_done`  out  1: one-cycle pulse after beat 15 is accepted.
- `overrun`  out  1: one-cycle pulse when a capture start is dropped.

## Operation
- Cell geometry:
  - cell = `hpos[7:4]`; only `hpos[8]==0` is sampled.
  - column `xofs = hpos[3:1]`; the drawn columns are 3..7, with 3 = left, 5 = middle, 7 = right.
  - line `yofs = vpos[4:2]`, lines 0..4.
- Sample points as (`yofs`, `xofs`) → segment bit:
  - (0,5) → 6, (1,3) → 1, (1,7) → 5
  - (2,5) → 0, (3,3) → 2, (3,7) → 4
  - (4,5) → 3
- Sample strobe fires when all of these hold:
  - state is CAPTURE, `display_on`, `vpos[8:5]==ROW`;
  - `vpos[1:0]==2`, `hpos[0]==1`, `hpos[8]==0`;
  - (`yofs`, `xofs`) is one of the sample points.
- On a strobe, `seg[cell][bit] <= pixel`. No other store writes occur.
- Row start: `vpos[8:5]==ROW && vpos[4:0]==0 && hpos==0`.
- Row end: `vpos[8:5]==ROW && vpos[4:0]==20 && hpos==0`.
- FSM:
  - IDLE: row start → clear all 16 masks, go to CAPTURE.
  - CAPTURE: row end → EMIT with beat pointer k=0.
  - EMIT: present beat k. On acceptance, k increments. Acceptance of k=15 → pulse `frame_done` and go to IDLE.
- Beat decode uses the inverse of the standard table, masks bit 6..0:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4
  - 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9
  - Any other mask gives `out_digit=4'hF` and `out_error=1`.
- A row start while in EMIT is ignored: the store is kept, `overrun` pulses for 1 cycle, and the frame is skipped. A row start while in CAPTURE cannot occur within one frame and is ignored.

## Timing
- Reset values: every output is 0, state IDLE, all masks 0, k=0. Reset takes effect immediately and asynchronously in any state. After release the block waits for the next row start; a partial row is never captured.
- Capture-to-output latency: entering EMIT on the row-end cycle sets `out_valid=1` on the next cycle with beat 0. All beat outputs are registered.
- Handshake:
  - transfer happens on a rising edge with `out_valid && out_ready`;
  - while `out_valid && !out_ready`, `out_digit`, `out_index` and `out_error` hold stable;
  - back-to-back beats run at 1 per cycle with ready held high.
- After beat 15 transfers, `out_valid` drops on the next cycle, in the same cycle `frame_done` is 1.
- With `out_ready` held high, all 16 beats finish in 16 cycles, well before the next frame.
- `overrun` and `frame_done` are both registered single-cycle pulses.
- `out_ready` is ignored when `out_valid=0`.

## Structure
- Shared package `seven_segment_pkg`:
  - segment bit-index constants (0..6);
  - the 10 segment patterns;
  - sample-point `xofs` constants 3, 5, 7;
  - FSM state enum IDLE, CAPTURE, EMIT;
  - row-end line constant 20.
- The renderer's decoder and this block both use the package patterns.
- Sub-module `seven_segment_encoder`: combinational, segments → {digit, error}, instanced once on the mask selected by k.

## Test plan
- Renderer loopback: drive the renderer with digits `hpos[7:4]`, ROW=0, ready high → 16 beats, index 0..15, digits 0,1,...,9 then 4'hF with error=1 for cells 10..15 (blank masks); `frame_done` pulses once.
- Backpressure: ready low for 5 cycles at beat 3 → beat 3 (digit 3) held for 6 cycles; then beats 4..15 follow one per cycle.
- Corrupt pattern: force `pixel=0` at (2,5) in cell 8 → beat 8 gives digit 0 (mask 1111110), error=0; force it in cell 1 only on line (1,3) high → mask 0110010, digit 4'hF, error=1.
- Overrun: ready low through the next frame's row start → `overrun` pulses once; after ready rises, the original beats are intact and no new capture has occurred.
- Reset mid-CAPTURE: assert reset at `vpos=10` → outputs 0 immediately; release → no beats that frame; the next frame captures normally.
- ROW=2: image drawn only in row 2 → correct digits; the same image in row 0 → all 4'hF with error set.
